// File: rtl/serial_adder_arbiter.sv
// Bit-serial adder shared by two requesters: round-robin grant, one full-add cell reused
// LSB-first for WIDTH cycles, result held until the consumer takes it.
module serial_adder_arbiter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_sum,
  output logic             res_carry,
  output logic             res_id,
  output logic             busy
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StAdd, StDone} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_q, b_q, sum_q, res_sum_q;
  logic [CntW-1:0]  cnt_q;
  logic             carry_q, id_q, last_id_q;
  logic             res_carry_q, res_id_q, res_valid_q;

  logic             grant0, grant1, acc0, acc1;
  logic             ha_p, ha_g, s_bit, c_next;
  logic [WIDTH-1:0] sum_next;

  // Ties go to whoever was not served last.
  always_comb begin
    grant0 = req0_valid & (~req1_valid | last_id_q);
    grant1 = req1_valid & (~req0_valid | ~last_id_q);
    req0_ready = rst_n & (state_q == StIdle) & grant0;
    req1_ready = rst_n & (state_q == StIdle) & grant1;
    acc0 = req0_valid & req0_ready;
    acc1 = req1_valid & req1_ready;
  end

  // The single shared full-add cell: two half adders plus an OR.
  always_comb begin
    ha_p     = a_q[0] ^ b_q[0];
    ha_g     = a_q[0] & b_q[0];
    s_bit    = ha_p ^ carry_q;
    c_next   = ha_g | (ha_p & carry_q);
    sum_next = {s_bit, sum_q[WIDTH-1:1]};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      id_q        <= 1'b0;
      last_id_q   <= 1'b1;
      res_sum_q   <= '0;
      res_carry_q <= 1'b0;
      res_id_q    <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (acc0 || acc1) begin
            a_q       <= acc1 ? req1_a : req0_a;
            b_q       <= acc1 ? req1_b : req0_b;
            sum_q     <= '0;
            carry_q   <= 1'b0;
            cnt_q     <= '0;
            id_q      <= acc1;
            last_id_q <= acc1;
            state_q   <= StAdd;
          end
        end
        StAdd: begin
          a_q     <= a_q >> 1;
          b_q     <= b_q >> 1;
          sum_q   <= sum_next;
          carry_q <= c_next;
          cnt_q   <= cnt_q + CntW'(1);
          if (cnt_q == LastCnt) begin
            res_sum_q   <= sum_next;
            res_carry_q <= c_next;
            res_id_q    <= id_q;
            res_valid_q <= 1'b1;
            state_q     <= StDone;
          end
        end
        StDone: begin
          if (res_ready) begin
            res_valid_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign res_valid = res_valid_q;
  assign res_sum   = res_sum_q;
  assign res_carry = res_carry_q;
  assign res_id    = res_id_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_serial_adder_arbiter.sv
// Directed vector table, hand-written corner sequences and random ops for serial_adder_arbiter,
// checked against an arithmetic model of arbitration and addition.
module tb_serial_adder_arbiter;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req0_valid, req0_ready, req1_valid, req1_ready;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic         res_valid, res_ready, res_carry, res_id, busy;
  logic [W-1:0] res_sum;

  serial_adder_arbiter #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_sum    (res_sum),
    .res_carry  (res_carry),
    .res_id     (res_id),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Model state: who was served last, and the last emitted result.
  logic         m_last;
  logic [W-1:0] m_prev_sum;
  logic         m_prev_carry, m_prev_id;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Both readies must never be high together.
  always begin
    @(negedge clk);
    #2;
    if (req0_ready === 1'b1 && req1_ready === 1'b1) begin
      n_fail++;
      $display("FAIL both_ready: got 11 expected at most one high (t=%0t)", $time);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; res_ready = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
    @(negedge clk);
    #1;
    check("reset_outputs", 32'({res_valid, busy, res_sum, res_carry, res_id, req0_ready,
                                req1_ready}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
    m_last = 1'b1; m_prev_sum = '0; m_prev_carry = 1'b0; m_prev_id = 1'b0;
  endtask

  // One full transaction from an IDLE cycle through the result handshake edge.
  task automatic run_op(input logic v0, input logic v1, input logic [W-1:0] a0, input logic [W-1:0] b0,
                        input logic [W-1:0] a1, input logic [W-1:0] b1, input int hold,
                        output logic [W-1:0] o_sum, output logic o_carry, output logic o_id,
                        output int acc_cyc);
    logic       g1;
    logic [W:0] full;
    g1   = v1 && (!v0 || (m_last == 1'b0));
    full = g1 ? ({1'b0, a1} + {1'b0, b1}) : ({1'b0, a0} + {1'b0, b0});
    @(negedge clk);
    req0_valid = v0; req1_valid = v1;
    req0_a = a0; req0_b = b0; req1_a = a1; req1_b = b1;
    res_ready = 1'b0;
    #1;
    check("idle_status", 32'({res_valid, busy}), 32'd0);
    check("retained_result", 32'({res_sum, res_carry, res_id}),
          32'({m_prev_sum, m_prev_carry, m_prev_id}));
    check("grant", 32'({req0_ready, req1_ready}), 32'({!g1, g1}));
    acc_cyc = cyc;
    m_last = g1;
    for (int i = 1; i <= int'(W); i++) begin
      @(negedge clk);
      // Operands wander while the add is in flight; the captured pair must win.
      req0_a = W'($urandom); req0_b = W'($urandom);
      req1_a = W'($urandom); req1_b = W'($urandom);
      #1;
      check("add_phase", 32'({busy, res_valid, req0_ready, req1_ready}), 32'b1000);
    end
    for (int h = 0; h <= hold; h++) begin
      @(negedge clk);
      req0_a = W'($urandom); req1_b = W'($urandom);
      res_ready = (h == hold);
      #1;
      check("done_status", 32'({busy, res_valid, req0_ready, req1_ready}), 32'b1100);
      check("done_result", 32'({res_sum, res_carry, res_id}), 32'({full[W-1:0], full[W], g1}));
    end
    o_sum = res_sum; o_carry = res_carry; o_id = res_id;
    m_prev_sum = full[W-1:0]; m_prev_carry = full[W]; m_prev_id = g1;
    @(posedge clk);
    #1;
    res_ready = 1'b0;
  endtask

  typedef struct {
    logic         v0, v1;
    logic [W-1:0] a0, b0, a1, b1;
    logic [W-1:0] exp_sum;
    logic         exp_carry, exp_id;
  } vec_t;

  vec_t         vecs[6];
  logic [W-1:0] o_sum;
  logic         o_carry, o_id;
  int           acc, prev_acc;

  initial begin
    vecs[0] = '{1'b1, 1'b0, 8'h0F, 8'h01, 8'h00, 8'h00, 8'h10, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 8'h00, 8'h00, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1};
    vecs[2] = '{1'b0, 1'b1, 8'h00, 8'h00, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1};
    vecs[3] = '{1'b1, 1'b0, 8'h55, 8'hAA, 8'h00, 8'h00, 8'hFF, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 1'b1, 8'h12, 8'h34, 8'hF0, 8'h20, 8'h10, 1'b1, 1'b1};
    vecs[5] = '{1'b1, 1'b1, 8'h12, 8'h34, 8'hF0, 8'h20, 8'h46, 1'b0, 1'b0};

    do_reset();
    prev_acc = 0;
    foreach (vecs[i]) begin
      run_op(vecs[i].v0, vecs[i].v1, vecs[i].a0, vecs[i].b0, vecs[i].a1, vecs[i].b1, 0,
             o_sum, o_carry, o_id, acc);
      check($sformatf("vec%0d_result", i), 32'({o_sum, o_carry, o_id}),
            32'({vecs[i].exp_sum, vecs[i].exp_carry, vecs[i].exp_id}));
    end

    // Both requesters valid from reset: strict alternation at WIDTH+2 spacing.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      run_op(1'b1, 1'b1, 8'(i + 1), 8'h10, 8'(8'hF0 + i), 8'h20, 0, o_sum, o_carry, o_id, acc);
      check($sformatf("tie_id%0d", i), 32'(o_id), 32'(i % 2));
      if (i > 0) check("accept_spacing", 32'(acc - prev_acc), 32'(W + 2));
      prev_acc = acc;
    end

    // Consumer stalls five cycles in DONE.
    run_op(1'b1, 1'b0, 8'h3C, 8'hC4, 8'h00, 8'h00, 5, o_sum, o_carry, o_id, acc);
    check("stall_result", 32'({o_sum, o_carry}), 32'({8'h00, 1'b1}));

    // Reset during the fourth ADD cycle discards the operation.
    @(negedge clk);
    req0_valid = 1'b1; req1_valid = 1'b0; req0_a = 8'h77; req0_b = 8'h11;
    #1;
    check("pre_abort_grant", 32'({req0_ready, req1_ready}), 32'b10);
    for (int i = 1; i <= 4; i++) @(negedge clk);
    rst_n = 1'b0; req1_valid = 1'b1;
    @(negedge clk);
    #1;
    check("abort_outputs", 32'({res_valid, busy, res_sum, res_carry, res_id, req0_ready,
                               req1_ready}), 32'd0);
    @(negedge clk);
    #1;
    check("abort_no_result", 32'({res_valid, busy}), 32'd0);
    rst_n = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
    m_last = 1'b1; m_prev_sum = '0; m_prev_carry = 1'b0; m_prev_id = 1'b0;
    run_op(1'b0, 1'b1, 8'h00, 8'h00, 8'hC8, 8'h64, 0, o_sum, o_carry, o_id, acc);
    check("post_abort_req1", 32'({o_sum, o_carry, o_id}), 32'({8'h2C, 1'b1, 1'b1}));
    run_op(1'b1, 1'b1, 8'h01, 8'h02, 8'h03, 8'h04, 0, o_sum, o_carry, o_id, acc);
    check("post_abort_tie", 32'({o_sum, o_id}), 32'({8'h03, 1'b0}));

    // Random traffic against the model.
    for (int i = 0; i < 40; i++) begin
      logic rv0, rv1;
      rv0 = 1'($urandom);
      rv1 = 1'($urandom);
      if (!rv0 && !rv1) rv0 = 1'b1;
      run_op(rv0, rv1, W'($urandom), W'($urandom), W'($urandom), W'($urandom),
             int'($urandom_range(0, 2)), o_sum, o_carry, o_id, acc);
    end

    @(negedge clk);
    #1;
    check("final_idle", 32'({res_valid, busy}), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
